// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// master: controller side (drives strobes/selects), slave: datapath side.
interface multicycle_ctrl_if;
  logic [5:0] Option;
  logic [5:0] Function;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Regwrite;
  logic       ALUSrc;
  logic [1:0] Regdst;
  logic [1:0] MemtoReg;
  logic [1:0] Sign;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;
  logic       instr_done;

  modport master (
    input  Option, Function, Zero, mem_ready,
    output PCWrite, IRWrite, MemRead, MemWrite, Regwrite, ALUSrc,
           Regdst, MemtoReg, Sign, PCSrc, ALUOp, state, instr_done
  );

  modport slave (
    output Option, Function, Zero, mem_ready,
    input  PCWrite, IRWrite, MemRead, MemWrite, Regwrite, ALUSrc,
           Regdst, MemtoReg, Sign, PCSrc, ALUOp, state, instr_done
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB.
// Optional memory wait states: define MULTICYCLE_CTRL_MEMWAIT_EN to stall
// FETCH and MEM until mem_ready=1.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NONE, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
  } instr_t;

  state_t cur, nxt;
  instr_t instr;
  logic   ready;
  logic   rtype;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
  assign ready = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign ready = 1'b1;
`endif

  // Classify the instruction register contents into a supported operation.
  always_comb begin
    instr = I_NONE;
    unique case (bus.Option)
      6'b000000: begin
        case (bus.Function)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_NONE;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_NONE;
    endcase
  end

  assign rtype = (instr == I_ADDU) || (instr == I_SUBU);

  // State register; unused encodings fall back to FETCH through nxt.
  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // Next-state and per-state control decode; reset masks every output.
  always_comb begin
    nxt            = cur;
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Regwrite   = 1'b0;
    bus.ALUSrc     = 1'b0;
    bus.Regdst     = '0;
    bus.MemtoReg   = '0;
    bus.Sign       = '0;
    bus.PCSrc      = '0;
    bus.ALUOp      = '0;
    bus.instr_done = 1'b0;

    case (cur)
      FETCH: begin
        bus.MemRead = 1'b1;
        if (ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          nxt         = DECODE;
        end
      end
      DECODE: begin
        if (instr == I_NONE) begin
          bus.instr_done = 1'b1;
          nxt            = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        case (instr)
          I_SUBU, I_BEQ: bus.ALUOp = 3'b001;
          I_ORI:         bus.ALUOp = 3'b010;
          I_LUI:         bus.ALUOp = 3'b011;
          default:       bus.ALUOp = 3'b000;
        endcase
        bus.ALUSrc = (instr == I_ORI) || (instr == I_LUI) ||
                     (instr == I_LW)  || (instr == I_SW);
        case (instr)
          I_LW, I_SW, I_BEQ: bus.Sign = 2'b01;
          I_LUI:             bus.Sign = 2'b10;
          default:           bus.Sign = 2'b00;
        endcase
        case (instr)
          I_BEQ: begin
            if (bus.Zero) begin
              bus.PCWrite = 1'b1;
              bus.PCSrc   = 2'b01;
            end
            bus.instr_done = 1'b1;
            nxt            = FETCH;
          end
          I_J: begin
            bus.PCWrite    = 1'b1;
            bus.PCSrc      = 2'b10;
            bus.instr_done = 1'b1;
            nxt            = FETCH;
          end
          I_JAL: begin
            bus.PCWrite    = 1'b1;
            bus.PCSrc      = 2'b10;
            bus.Regwrite   = 1'b1;
            bus.Regdst     = 2'b10;
            bus.MemtoReg   = 2'b10;
            bus.instr_done = 1'b1;
            nxt            = FETCH;
          end
          I_JR: begin
            bus.PCWrite    = 1'b1;
            bus.PCSrc      = 2'b11;
            bus.instr_done = 1'b1;
            nxt            = FETCH;
          end
          I_LW, I_SW: nxt = MEM;
          I_NONE: begin
            bus.instr_done = 1'b1;
            nxt            = FETCH;
          end
          default: nxt = WB;
        endcase
      end
      MEM: begin
        case (instr)
          I_LW: begin
            bus.MemRead = 1'b1;
            if (ready) nxt = WB;
          end
          I_SW: begin
            bus.MemWrite = 1'b1;
            if (ready) begin
              bus.instr_done = 1'b1;
              nxt            = FETCH;
            end
          end
          default: nxt = FETCH;
        endcase
      end
      WB: begin
        bus.Regwrite   = 1'b1;
        bus.Regdst     = rtype ? 2'b01 : 2'b00;
        bus.MemtoReg   = (instr == I_LW) ? 2'b01 : 2'b00;
        bus.instr_done = 1'b1;
        nxt            = FETCH;
      end
      default: nxt = FETCH;
    endcase

    if (reset) begin
      bus.PCWrite    = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.Regwrite   = 1'b0;
      bus.ALUSrc     = 1'b0;
      bus.Regdst     = '0;
      bus.MemtoReg   = '0;
      bus.Sign       = '0;
      bus.PCSrc      = '0;
      bus.ALUOp      = '0;
      bus.instr_done = 1'b0;
    end
  end

  assign bus.state = cur;

endmodule
